multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Control FSM for the 8-bit-PC multicycle MIPS-subset datapath.
- Consumes Op, Function and Zero from the datapath. Drives every datapath control strobe, one instruction at a time.
- Adds an illegal-instruction flag, a halt option and a retired-instruction counter for bring-up and verification.

Parameters:
HALT_ON_ILLEGAL, 0, 1 = illegal instruction parks FSM in HALT until reset; 0 = skip it and refetch
CNT_W, 16, width of retired-instruction counter

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high
Op  in  6  instruction[31:26] from datapath
Function  in  6  instruction[5:0] from datapath
Zero  in  1  combinational ALUResult==0 from datapath
IorD  out  1  memory address select, 1 = ALUOut, 0 = PC
MemRead  out  1  memory read enable
MemWrite  out  1  memory write of B at address
MemtoReg  out  1  register write data, 1 = MDR, 0 = ALUOut
IRWrite  out  1  instruction register load
PCSource  out  1  PC next value, 0 = ALUResult, 1 = ALUOut
ALUSrcB  out  2  00 = B, 01 = constant 1, 10 = sign-extended imm
ALUSrcA  out  1  0 = PC, 1 = A
RegWrite  out  1  register file write
RegDst  out  1  1 = rd, 0 = rt
PCSel  out  1  PC load enable
ALUCtrl  out  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR
Illegal  out  1  one-cycle pulse in DECODE on unsupported Op/Function
Halted  out  1  high while in HALT
Retired  out  CNT_W  count of completed instructions, wraps modulo 2^CNT_W

Behaviour:
- Reset: state=FETCH at next edge. While reset is high, all strobes are 0, ALUSrcB=00, ALUCtrl=0010, Illegal=0, Halted=0. Retired is cleared to 0. Reset mid-instruction aborts it; no write strobe may be asserted during reset.
- Outputs are Moore decodes of state, except PCSel in BEQ/BNE, which is combinational on Zero.
- Default in every state: all strobes 0, ALUSrcB=00, ALUCtrl=0010.
- Supported: R-type (Op 00) with Function 20 add, 22 sub, 24 and, 25 or, 27 nor, 2A slt. Also lw 23, sw 2B, beq 04, bne 05, addi 08 (all hex).
- FETCH: MemRead=1, IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=01, ADD, PCSource=0, PCSel=1 (PC<=PC+1). Next: DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=10, ADD, so ALUOut latches the branch target PC+imm. Next state by Op:
  - lw/sw -> MEMADR
  - R-type -> EXEC
  - beq -> BEQ
  - bne -> BNE
  - addi -> ADDIEX
  - unsupported Op, or R-type with unsupported Function: Illegal=1, next HALT if HALT_ON_ILLEGAL else FETCH.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ADD. Next: MEMRD for lw, MEMWR for sw.
- MEMRD: IorD=1, MemRead=1, ALU controls held as MEMADR. Next: MEMWB.
- MEMWB: RegWrite=1, RegDst=0, MemtoReg=1. Next: FETCH.
- MEMWR: IorD=1, MemWrite=1, ALU controls held as MEMADR. Next: FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUCtrl from Function. Next: RTYPEWB.
- RTYPEWB: RegWrite=1, RegDst=1, MemtoReg=0. Next: FETCH.
- BEQ: ALUSrcA=1, ALUSrcB=00, SUB, PCSource=1, PCSel=Zero. Next: FETCH.
- BNE: same as BEQ with PCSel=~Zero. Next: FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ADD. Next: ADDIWB.
- ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0. Next: FETCH.
- HALT: all strobes 0, Halted=1. Leaves only on reset.
- Latency (cycles, FETCH inclusive): lw 5, sw 4, R-type 4, addi 4, beq/bne 3, illegal 2.
- Retired increments by 1 on the edge leaving MEMWB, MEMWR, RTYPEWB, ADDIWB, BEQ or BNE. Illegal instructions do not count. All-ones wraps to 0.
- Op/Function are sampled only in DECODE/EXEC; they are stable because IRWrite is asserted only in FETCH.
- Write strobes (MemWrite, RegWrite, IRWrite, PCSel) are never asserted in the same cycle as one another, except IRWrite+PCSel in FETCH.

Decomposition:
- Shared package:
  - state encoding (4-bit enum: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, RTYPEWB, BEQ, BNE, ADDIEX, ADDIWB, HALT)
  - opcode and Function constants
  - ALUCtrl codes
  - ALUSrcB select codes
- One sub-module: alu_decoder, mapping a 2-bit ALUOp (add/sub/funct) plus Function to ALUCtrl, purely combinational. The FSM and counter live in multicycle_controller.

Test Plan:
- Reset held 3 cycles then released -> all strobes 0 and Retired=0 during reset. First cycle after release is FETCH with MemRead=IRWrite=PCSel=1, ALUSrcB=01, ALUCtrl=0010.
- Op=23 (lw) -> state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB. IorD=1 in MEMRD. RegWrite=1, MemtoReg=1, RegDst=0 in MEMWB. Retired 0->1 after 5 cycles.
- Op=00, Function=2A (slt) -> EXEC drives ALUCtrl=0111, ALUSrcA=1, ALUSrcB=00. RTYPEWB drives RegWrite=1, RegDst=1. Function=27 -> ALUCtrl=1100.
- Op=04 with Zero=1 -> BEQ PCSel=1, PCSource=1. Zero=0 -> PCSel=0. Op=05 with Zero=0 -> PCSel=1. Each takes 3 cycles.
- Op=3F, HALT_ON_ILLEGAL=0 -> Illegal pulses 1 cycle in DECODE, next state FETCH, Retired unchanged. With HALT_ON_ILLEGAL=1 -> Halted=1 persists for 20 cycles until reset.
- CNT_W=4, run 16 sw instructions -> Retired wraps 15->0. Reset asserted mid-MEMWR -> MemWrite=0 next cycle, state returns to FETCH.

Source files
------------

// File: rtl/multicycle_controller_pkg.sv
// multicycle_controller_pkg: shared states, opcodes, function codes and ALU encodings
package multicycle_controller_pkg;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC,
    S_RTYPEWB, S_BEQ, S_BNE, S_ADDIEX, S_ADDIWB, S_HALT
  } state_t;
  typedef enum logic [1:0] {ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT} aluop_t;
  localparam logic [5:0] OP_RTYPE = 6'h00, OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] OP_BEQ = 6'h04, OP_BNE = 6'h05, OP_ADDI = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24;
  localparam logic [5:0] FN_OR = 6'h25, FN_NOR = 6'h27, FN_SLT = 6'h2A;
  localparam logic [3:0] ALU_AND = 4'b0000, ALU_OR = 4'b0001, ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110, ALU_SLT = 4'b0111, ALU_NOR = 4'b1100;
  localparam logic [1:0] SRCB_B = 2'b00, SRCB_ONE = 2'b01, SRCB_IMM = 2'b10;
  function automatic logic fn_ok(input logic [5:0] f);
    return f inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_NOR, FN_SLT};
  endfunction
endpackage

// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: datapath <-> controller signals; master = datapath, slave = controller
interface multicycle_controller_if #(parameter int CNT_W = 16);
  logic [5:0] Op, Function;
  logic Zero;
  logic IorD, MemRead, MemWrite, MemtoReg, IRWrite, PCSource;
  logic [1:0] ALUSrcB;
  logic ALUSrcA, RegWrite, RegDst, PCSel;
  logic [3:0] ALUCtrl;
  logic Illegal, Halted;
  logic [CNT_W-1:0] Retired;
  modport master(
    output Op, Function, Zero,
    input IorD, MemRead, MemWrite, MemtoReg, IRWrite, PCSource, ALUSrcB,
    input ALUSrcA, RegWrite, RegDst, PCSel, ALUCtrl, Illegal, Halted, Retired
  );
  modport slave(
    input Op, Function, Zero,
    output IorD, MemRead, MemWrite, MemtoReg, IRWrite, PCSource, ALUSrcB,
    output ALUSrcA, RegWrite, RegDst, PCSel, ALUCtrl, Illegal, Halted, Retired
  );
endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// alu_decoder: maps ALUOp plus Function to the 4-bit ALU control code
module alu_decoder import multicycle_controller_pkg::*; (
  input  aluop_t     i_alu_op,
  input  logic [5:0] i_funct,
  output logic [3:0] o_alu_ctrl
);
  logic [3:0] w_funct_ctrl;
  always_comb begin
    w_funct_ctrl = i_funct == FN_SUB ? ALU_SUB :
                   i_funct == FN_AND ? ALU_AND :
                   i_funct == FN_OR  ? ALU_OR  :
                   i_funct == FN_NOR ? ALU_NOR :
                   i_funct == FN_SLT ? ALU_SLT : ALU_ADD;
    o_alu_ctrl = i_alu_op == ALUOP_ADD ? ALU_ADD :
                 i_alu_op == ALUOP_SUB ? ALU_SUB : w_funct_ctrl;
  end
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: control FSM for the multicycle MIPS-subset datapath,
// with illegal-instruction detection, optional halt and a retired-instruction counter
module multicycle_controller import multicycle_controller_pkg::*; #(
  parameter bit HALT_ON_ILLEGAL = 1'b0,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic reset,
  multicycle_controller_if.slave bus
);
  state_t r_state, w_next;
  aluop_t w_alu_op;
  logic [CNT_W-1:0] r_retired;
  logic w_legal, w_retire;
  assign w_legal = bus.Op inside {OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI} ||
                   (bus.Op == OP_RTYPE && fn_ok(bus.Function));
  assign w_retire = r_state inside {S_MEMWB, S_MEMWR, S_RTYPEWB, S_ADDIWB, S_BEQ, S_BNE};
  assign bus.Retired = r_retired;
  alu_decoder u_alu_dec (.i_alu_op(w_alu_op), .i_funct(bus.Function), .o_alu_ctrl(bus.ALUCtrl));
  always_ff @(posedge clk) begin
    r_state <= reset ? S_FETCH : w_next;
    r_retired <= reset ? '0 : r_retired + CNT_W'(w_retire);
  end
  // Outputs are forced to their idle values while reset is high, whatever the state register holds
  always_comb begin
    w_next = r_state;
    w_alu_op = ALUOP_ADD;
    bus.IorD = 1'b0;
    bus.MemRead = 1'b0;
    bus.MemWrite = 1'b0;
    bus.MemtoReg = 1'b0;
    bus.IRWrite = 1'b0;
    bus.PCSource = 1'b0;
    bus.ALUSrcB = SRCB_B;
    bus.ALUSrcA = 1'b0;
    bus.RegWrite = 1'b0;
    bus.RegDst = 1'b0;
    bus.PCSel = 1'b0;
    bus.Illegal = 1'b0;
    bus.Halted = 1'b0;
    if (!reset) begin
      case (r_state)
        S_FETCH: begin
          bus.MemRead = 1'b1;
          bus.IRWrite = 1'b1;
          bus.ALUSrcB = SRCB_ONE;
          bus.PCSel = 1'b1;
          w_next = S_DECODE;
        end
        S_DECODE: begin
          bus.ALUSrcB = SRCB_IMM;
          bus.Illegal = !w_legal;
          w_next = !w_legal ? (HALT_ON_ILLEGAL ? S_HALT : S_FETCH) :
                   bus.Op == OP_RTYPE ? S_EXEC :
                   bus.Op == OP_BEQ   ? S_BEQ  :
                   bus.Op == OP_BNE   ? S_BNE  :
                   bus.Op == OP_ADDI  ? S_ADDIEX : S_MEMADR;
        end
        S_MEMADR, S_ADDIEX: begin
          bus.ALUSrcA = 1'b1;
          bus.ALUSrcB = SRCB_IMM;
          w_next = r_state == S_ADDIEX ? S_ADDIWB : bus.Op == OP_LW ? S_MEMRD : S_MEMWR;
        end
        S_MEMRD, S_MEMWR: begin
          bus.IorD = 1'b1;
          bus.MemRead = r_state == S_MEMRD;
          bus.MemWrite = r_state == S_MEMWR;
          bus.ALUSrcA = 1'b1;
          bus.ALUSrcB = SRCB_IMM;
          w_next = r_state == S_MEMRD ? S_MEMWB : S_FETCH;
        end
        S_MEMWB, S_RTYPEWB, S_ADDIWB: begin
          bus.RegWrite = 1'b1;
          bus.MemtoReg = r_state == S_MEMWB;
          bus.RegDst = r_state == S_RTYPEWB;
          w_next = S_FETCH;
        end
        S_EXEC: begin
          bus.ALUSrcA = 1'b1;
          w_alu_op = ALUOP_FUNCT;
          w_next = S_RTYPEWB;
        end
        S_BEQ, S_BNE: begin
          bus.ALUSrcA = 1'b1;
          w_alu_op = ALUOP_SUB;
          bus.PCSource = 1'b1;
          bus.PCSel = bus.Zero ^ (r_state == S_BNE);
          w_next = S_FETCH;
        end
        S_HALT: bus.Halted = 1'b1;
        default: w_next = S_FETCH;
      endcase
    end
  end
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: randomized instruction-level check of two controller configurations
module tb_multicycle_controller;
  typedef logic [17:0] vec_t;
  logic clk = 1'b0, reset = 1'b1;
  logic [5:0] op = 6'h00, fn = 6'h20;
  logic zero = 1'b0;
  int n_vec = 0, n_bad = 0, ret0 = 0, ret1 = 0;
  bit halted1 = 1'b0;
  vec_t obs0, obs1;
  always #5 clk = ~clk;
  multicycle_controller_if #(.CNT_W(16)) if0 ();
  multicycle_controller_if #(.CNT_W(4)) if1 ();
  assign if0.Op = op;
  assign if0.Function = fn;
  assign if0.Zero = zero;
  assign if1.Op = op;
  assign if1.Function = fn;
  assign if1.Zero = zero;
  multicycle_controller #(.HALT_ON_ILLEGAL(1'b0), .CNT_W(16)) u0 (.clk(clk), .reset(reset), .bus(if0.slave));
  multicycle_controller #(.HALT_ON_ILLEGAL(1'b1), .CNT_W(4)) u1 (.clk(clk), .reset(reset), .bus(if1.slave));
  assign obs0 = {if0.IorD, if0.MemRead, if0.MemWrite, if0.MemtoReg, if0.IRWrite, if0.PCSource,
                 if0.ALUSrcB, if0.ALUSrcA, if0.RegWrite, if0.RegDst, if0.PCSel, if0.ALUCtrl,
                 if0.Illegal, if0.Halted};
  assign obs1 = {if1.IorD, if1.MemRead, if1.MemWrite, if1.MemtoReg, if1.IRWrite, if1.PCSource,
                 if1.ALUSrcB, if1.ALUSrcA, if1.RegWrite, if1.RegDst, if1.PCSel, if1.ALUCtrl,
                 if1.Illegal, if1.Halted};

  function automatic vec_t cv(input bit iord, mrd, mwr, m2r, irw, pcs, input logic [1:0] srcb,
                              input bit srca, rw, rd, pcsel, input logic [3:0] alu, input bit ill, hlt);
    return {iord, mrd, mwr, m2r, irw, pcs, srcb, srca, rw, rd, pcsel, alu, ill, hlt};
  endfunction
  localparam vec_t RST_V  = 18'b0000_0000_0000_0010_00;
  localparam vec_t HALT_V = 18'b0000_0000_0000_0010_01;

  function automatic bit legal(input logic [5:0] o, f);
    return o inside {6'h23, 6'h2B, 6'h04, 6'h05, 6'h08} ||
           (o == 6'h00 && f inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A});
  endfunction
  function automatic logic [3:0] alu_of(input logic [5:0] f);
    case (f)
      6'h22: return 4'b0110;
      6'h24: return 4'b0000;
      6'h25: return 4'b0001;
      6'h27: return 4'b1100;
      6'h2A: return 4'b0111;
      default: return 4'b0010;
    endcase
  endfunction
  function automatic int latency(input logic [5:0] o, f);
    if (!legal(o, f)) return 2;
    if (o == 6'h23) return 5;
    if (o == 6'h04 || o == 6'h05) return 3;
    return 4;
  endfunction
  // Expected control vector for cycle k of one instruction, k=0 being FETCH
  function automatic vec_t expect_at(input logic [5:0] o, f, input logic z, input int k);
    if (k == 0) return cv(0,1,0,0,1,0,2'b01,0,0,0,1,4'b0010,0,0);
    if (k == 1) return cv(0,0,0,0,0,0,2'b10,0,0,0,0,4'b0010,!legal(o, f),0);
    case (o)
      6'h23, 6'h2B: begin
        if (k == 2) return cv(0,0,0,0,0,0,2'b10,1,0,0,0,4'b0010,0,0);
        if (o == 6'h2B) return cv(1,0,1,0,0,0,2'b10,1,0,0,0,4'b0010,0,0);
        if (k == 3) return cv(1,1,0,0,0,0,2'b10,1,0,0,0,4'b0010,0,0);
        return cv(0,0,0,1,0,0,2'b00,0,1,0,0,4'b0010,0,0);
      end
      6'h04, 6'h05: return cv(0,0,0,0,0,1,2'b00,1,0,0,(o == 6'h04) ? z : !z,4'b0110,0,0);
      6'h08: return (k == 2) ? cv(0,0,0,0,0,0,2'b10,1,0,0,0,4'b0010,0,0)
                             : cv(0,0,0,0,0,0,2'b00,0,1,0,0,4'b0010,0,0);
      default: return (k == 2) ? cv(0,0,0,0,0,0,2'b00,1,0,0,0,alu_of(f),0,0)
                               : cv(0,0,0,0,0,0,2'b00,0,1,1,0,4'b0010,0,0);
    endcase
  endfunction

  // Runs one instruction (or its first `cycles` cycles when cycles >= 0); starts in the low phase
  task automatic run_instr(input logic [5:0] o, f, input logic z, input int cycles = -1);
    int lat = latency(o, f);
    int n = (cycles < 0) ? lat : cycles;
    vec_t e0, e1;
    op = o; fn = f; zero = z;
    for (int k = 0; k < n; k++) begin
      #1;
      e0 = expect_at(o, f, z, k);
      e1 = halted1 ? HALT_V : e0;
      n_vec += 4;
      if (obs0 !== e0) begin n_bad++; $display("FAIL ctrl0 op=%h fn=%h z=%0b k=%0d got=%b exp=%b", o, f, z, k, obs0, e0); end
      if (obs1 !== e1) begin n_bad++; $display("FAIL ctrl1 op=%h fn=%h z=%0b k=%0d got=%b exp=%b", o, f, z, k, obs1, e1); end
      if (if0.Retired !== 16'(ret0)) begin n_bad++; $display("FAIL retired0 k=%0d got=%0d exp=%0d", k, if0.Retired, ret0); end
      if (if1.Retired !== 4'(ret1)) begin n_bad++; $display("FAIL retired1 k=%0d got=%0d exp=%0d", k, if1.Retired, ret1); end
      if (k == n - 1 && n == lat) begin
        if (legal(o, f)) begin
          ret0 = (ret0 + 1) % 65536;
          if (!halted1) ret1 = (ret1 + 1) % 16;
        end else halted1 = 1'b1;
      end
      @(negedge clk);
    end
  endtask

  task automatic rand_legal();
    logic [5:0] ops [6] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08};
    logic [5:0] fns [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};
    logic [5:0] o = ops[$urandom_range(0, 5)];
    run_instr(o, (o == 6'h00) ? fns[$urandom_range(0, 5)] : 6'($urandom), 1'($urandom));
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk); #1;
      n_vec += 3;
      if (obs0 !== RST_V) begin n_bad++; $display("FAIL reset_ctrl0 got=%b exp=%b", obs0, RST_V); end
      if (obs1 !== RST_V) begin n_bad++; $display("FAIL reset_ctrl1 got=%b exp=%b", obs1, RST_V); end
      if (if0.Retired !== 16'd0 || if1.Retired !== 4'd0) begin
        n_bad++; $display("FAIL reset_retired got=%0d/%0d exp=0", if0.Retired, if1.Retired);
      end
    end
    reset = 1'b0;
    ret0 = 0; ret1 = 0; halted1 = 1'b0;
  endtask

  task automatic test_lw();
    run_instr(6'h23, 6'($urandom), 1'b0);
    run_instr(6'h23, 6'($urandom), 1'b1);
  endtask

  task automatic test_rtype();
    logic [5:0] fns [6] = '{6'h2A, 6'h27, 6'h20, 6'h22, 6'h24, 6'h25};
    foreach (fns[i]) run_instr(6'h00, fns[i], 1'($urandom));
    run_instr(6'h08, 6'($urandom), 1'b0);
    run_instr(6'h2B, 6'($urandom), 1'b1);
  endtask

  task automatic test_branch();
    run_instr(6'h04, 6'($urandom), 1'b1);
    run_instr(6'h04, 6'($urandom), 1'b0);
    run_instr(6'h05, 6'($urandom), 1'b0);
    run_instr(6'h05, 6'($urandom), 1'b1);
  endtask

  task automatic test_illegal_halt();
    int cyc = 0;
    run_instr(6'h3F, 6'($urandom), 1'b0);
    while (cyc < 20) begin
      cyc += 4;
      rand_legal();
    end
    run_instr(6'h00, 6'h21, 1'b0);
    test_reset();
  endtask

  task automatic test_wrap();
    repeat (16) run_instr(6'h2B, 6'($urandom), 1'($urandom));
    #1;
    n_vec += 2;
    if (if1.Retired !== 4'd0) begin n_bad++; $display("FAIL wrap_retired1 got=%0d exp=0", if1.Retired); end
    if (if0.Retired !== 16'd16) begin n_bad++; $display("FAIL wrap_retired0 got=%0d exp=16", if0.Retired); end
  endtask

  task automatic test_random();
    repeat (40) begin
      if ($urandom_range(0, 9) == 0) run_instr(6'h3E, 6'($urandom), 1'($urandom));
      else rand_legal();
    end
    test_reset();
  endtask

  task automatic test_reset_mid();
    run_instr(6'h2B, 6'h00, 1'b0, 3);
    #1;
    n_vec += 1;
    if (if0.MemWrite !== 1'b1) begin n_bad++; $display("FAIL midreset_pre got=%b exp=1", if0.MemWrite); end
    reset = 1'b1;
    #1;
    n_vec += 2;
    if (obs0 !== RST_V) begin n_bad++; $display("FAIL midreset_ctrl0 got=%b exp=%b", obs0, RST_V); end
    if (obs1 !== RST_V) begin n_bad++; $display("FAIL midreset_ctrl1 got=%b exp=%b", obs1, RST_V); end
    @(negedge clk); #1;
    n_vec += 2;
    if (if0.MemWrite !== 1'b0 || if1.MemWrite !== 1'b0) begin
      n_bad++; $display("FAIL midreset_memwrite got=%b/%b exp=0", if0.MemWrite, if1.MemWrite);
    end
    if (if0.Retired !== 16'd0) begin n_bad++; $display("FAIL midreset_retired got=%0d exp=0", if0.Retired); end
    reset = 1'b0;
    ret0 = 0; ret1 = 0; halted1 = 1'b0;
    run_instr(6'h23, 6'h00, 1'b0);
  endtask

  initial begin
    test_reset();
    test_lw();
    test_rtype();
    test_branch();
    test_illegal_halt();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
